// File: rtl/err_mask_gen.sv
// rtl/err_mask_gen.sv - per-port none/single/double error mask generator with LFSR positions
module err_mask_port #(
    parameter int          DATA = 16,
    parameter logic [15:0] SEED = 16'h0001
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req,
    input  logic [1:0]              i_mode,
    input  logic                    i_rand,
    input  logic [$clog2(DATA)-1:0] i_pos0,
    input  logic [$clog2(DATA)-1:0] i_pos1,
    input  logic                    i_ack,
    output logic [DATA-1:0]         o_temp,
    output logic                    o_valid,
    output logic                    o_dbit_err,
    output logic [15:0]             o_err_cnt
);
    localparam int PW = $clog2(DATA);
    localparam int unsigned DATA_U = DATA;
    localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [DATA-1:0] ONE = DATA'(1);

    typedef enum logic [1:0] {IDLE, CALC, VALID} state_t;
    typedef enum logic [1:0] {K_NONE, K_SINGLE, K_DOUBLE} kind_t;

    state_t          state_q;
    logic [15:0]     lfsr_q, lfsr_d, lfsr_cap_q;
    logic [1:0]      mode_q;
    logic            rand_q;
    logic [PW-1:0]   pos0_q, pos1_q;
    logic [DATA-1:0] temp_q, mask_d;
    logic            valid_q, dbit_q, dbit_d;
    logic [15:0]     cnt_q;
    int unsigned     p0, p1;
    kind_t           kind;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

        p0 = rand_q ? 32'(lfsr_cap_q[7:0])  : 32'(pos0_q);
        p1 = rand_q ? 32'(lfsr_cap_q[15:8]) : 32'(pos1_q);
        p0 = p0 % DATA_U;
        p1 = p1 % DATA_U;
        // Colliding positions would collapse a double into a single bit.
        if (p1 == p0) p1 = (p0 + 1) % DATA_U;

        case (mode_q)
            2'b00:   kind = K_NONE;
            2'b01:   kind = K_SINGLE;
            2'b10:   kind = K_DOUBLE;
            default: kind = (lfsr_cap_q[1:0] == 2'b00) ? K_NONE :
                            (lfsr_cap_q[1:0] == 2'b01) ? K_SINGLE : K_DOUBLE;
        endcase

        mask_d = '0;
        if (kind != K_NONE) mask_d = ONE << p0;
        if (kind == K_DOUBLE) mask_d = mask_d | (ONE << p1);
        dbit_d = (kind == K_DOUBLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED_NZ;
            lfsr_cap_q <= '0;
            mode_q     <= '0;
            rand_q     <= 1'b0;
            pos0_q     <= '0;
            pos1_q     <= '0;
            temp_q     <= '0;
            valid_q    <= 1'b0;
            dbit_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            case (state_q)
                IDLE: begin
                    if (i_req) begin
                        mode_q     <= i_mode;
                        rand_q     <= i_rand;
                        pos0_q     <= i_pos0;
                        pos1_q     <= i_pos1;
                        lfsr_cap_q <= lfsr_q;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    temp_q  <= mask_d;
                    dbit_q  <= dbit_d;
                    state_q <= VALID;
                end
                VALID: begin
                    // First VALID cycle raises o_valid; acks count only once it is visible.
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (i_ack) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                        if (temp_q != '0 && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_temp     = temp_q;
    assign o_valid    = valid_q;
    assign o_dbit_err = dbit_q;
    assign o_err_cnt  = cnt_q;
endmodule

module err_mask_gen #(
    parameter int          DATA_A = 16,
    parameter int          DATA_B = DATA_A,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_req_a,
    input  logic [1:0]                i_mode_a,
    input  logic                      i_rand_a,
    input  logic [$clog2(DATA_A)-1:0] i_pos0_a,
    input  logic [$clog2(DATA_A)-1:0] i_pos1_a,
    input  logic                      i_ack_a,
    output logic [DATA_A-1:0]         o_temp_a,
    output logic                      o_valid_a,
    output logic                      o_dbit_err_a,
    output logic [15:0]               o_err_cnt_a,
    input  logic                      i_req_b,
    input  logic [1:0]                i_mode_b,
    input  logic                      i_rand_b,
    input  logic [$clog2(DATA_B)-1:0] i_pos0_b,
    input  logic [$clog2(DATA_B)-1:0] i_pos1_b,
    input  logic                      i_ack_b,
    output logic [DATA_B-1:0]         o_temp_b,
    output logic                      o_valid_b,
    output logic                      o_dbit_err_b,
    output logic [15:0]               o_err_cnt_b
);
    localparam logic [15:0] SEED_B = SEED ^ 16'h5A5A;

    err_mask_port #(.DATA(DATA_A), .SEED(SEED)) u_port_a (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req      (i_req_a),
        .i_mode     (i_mode_a),
        .i_rand     (i_rand_a),
        .i_pos0     (i_pos0_a),
        .i_pos1     (i_pos1_a),
        .i_ack      (i_ack_a),
        .o_temp     (o_temp_a),
        .o_valid    (o_valid_a),
        .o_dbit_err (o_dbit_err_a),
        .o_err_cnt  (o_err_cnt_a)
    );

    err_mask_port #(.DATA(DATA_B), .SEED(SEED_B)) u_port_b (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req      (i_req_b),
        .i_mode     (i_mode_b),
        .i_rand     (i_rand_b),
        .i_pos0     (i_pos0_b),
        .i_pos1     (i_pos1_b),
        .i_ack      (i_ack_b),
        .o_temp     (o_temp_b),
        .o_valid    (o_valid_b),
        .o_dbit_err (o_dbit_err_b),
        .o_err_cnt  (o_err_cnt_b)
    );
endmodule
